// File: rtl/mem_read_arbiter_pkg.sv
// Shared memory-path constants and client identifiers for the read arbiter and its tag FIFO.
package mem_read_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 27;
    localparam int unsigned MEM_DATA_W = 128;

    typedef enum logic [1:0] {
        CLIENT_FB  = 2'd0,
        CLIENT_BVH = 2'd1
    } client_e;

endpackage

// File: rtl/mem_read_tag_fifo.sv
// In-order FIFO of client tags, one entry per outstanding memory read.
module mem_read_tag_fifo
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned Width = 1,
    parameter int unsigned Depth = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    push_i,
    input  logic [Width-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [Width-1:0]        pop_data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (PtrW + 1)'(Depth));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin merge of client read requests onto the memory-controller read port, with
// in-order routing of returned beats back to the issuing client.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned ADDR_W      = MEM_ADDR_W,
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned TAG_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_CLIENTS-1:0]        cl_req_valid_i,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_req_addr_i,
    output logic [NUM_CLIENTS-1:0]        cl_req_ready_o,
    output logic [NUM_CLIENTS-1:0]        cl_rsp_valid_o,
    output logic [DATA_W-1:0]             cl_rsp_data_o,
    output logic                          mc_req_valid_o,
    output logic [ADDR_W-1:0]             mc_req_addr_o,
    input  logic                          mc_req_ready_i,
    input  logic                          mc_rsp_valid_i,
    input  logic [DATA_W-1:0]             mc_rsp_data_i,
    output logic [$clog2(TAG_DEPTH):0]    outstanding_o,
    output logic                          err_orphan_o
);

    localparam int unsigned CW = $clog2(NUM_CLIENTS);

    logic [ADDR_W-1:0]      cl_addr [NUM_CLIENTS];
    logic [CW-1:0]          last_grant_q;
    logic [CW-1:0]          grant_idx;
    logic [CW-1:0]          cand;
    logic                   grant_valid;
    logic                   slot_free;
    logic                   accept;
    logic                   tag_full;
    logic                   tag_empty;
    logic                   tag_pop;
    logic [CW-1:0]          tag_head;
    logic                   mc_req_valid_q;
    logic [ADDR_W-1:0]      mc_req_addr_q;
    logic [NUM_CLIENTS-1:0] cl_rsp_valid_q;
    logic [DATA_W-1:0]      cl_rsp_data_q;
    logic                   err_orphan_q;

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_addr
        assign cl_addr[g] = cl_req_addr_i[g*ADDR_W +: ADDR_W];
    end

    // Search begins one past the last granted client so every requester gets a turn.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
            cand = CW'((32'(last_grant_q) + k) % NUM_CLIENTS);
            if (!grant_valid && cl_req_valid_i[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign slot_free = !mc_req_valid_q || mc_req_ready_i;

    always_comb begin
        cl_req_ready_o = '0;
        if (resetn && grant_valid && slot_free && !tag_full) begin
            cl_req_ready_o[grant_idx] = 1'b1;
        end
    end

    assign accept  = |(cl_req_valid_i & cl_req_ready_o);
    assign tag_pop = mc_rsp_valid_i && !tag_empty;

    mem_read_tag_fifo #(
        .Width (CW),
        .Depth (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (accept),
        .push_data_i (grant_idx),
        .pop_i       (tag_pop),
        .pop_data_o  (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (outstanding_o)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q   <= '0;
            mc_req_valid_q <= 1'b0;
            mc_req_addr_q  <= '0;
            cl_rsp_valid_q <= '0;
            cl_rsp_data_q  <= '0;
            err_orphan_q   <= 1'b0;
        end else begin
            if (accept) begin
                mc_req_valid_q <= 1'b1;
                mc_req_addr_q  <= cl_addr[grant_idx];
                last_grant_q   <= grant_idx;
            end else if (mc_req_ready_i) begin
                mc_req_valid_q <= 1'b0;
            end
            cl_rsp_valid_q <= '0;
            if (tag_pop) begin
                cl_rsp_valid_q[tag_head] <= 1'b1;
                cl_rsp_data_q            <= mc_rsp_data_i;
            end
            // A beat with nothing outstanding is dropped but stays visible until reset.
            if (mc_rsp_valid_i && tag_empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    assign mc_req_valid_o = mc_req_valid_q;
    assign mc_req_addr_o  = mc_req_addr_q;
    assign cl_rsp_valid_o = cl_rsp_valid_q;
    assign cl_rsp_data_o  = cl_rsp_data_q;
    assign err_orphan_o   = err_orphan_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed vector table, reset sequences, then random traffic
// against a queue-based reference model.
module tb_mem_read_arbiter;
    import mem_read_arbiter_pkg::*;

    localparam int unsigned N     = 2;
    localparam int unsigned AW    = MEM_ADDR_W;
    localparam int unsigned DW    = MEM_DATA_W;
    localparam int unsigned DEPTH = 8;

    localparam logic [AW-1:0] A_SR = 27'h0001000;
    localparam logic [AW-1:0] A_BP = 27'h0ABCDEF;
    localparam logic [AW-1:0] A_X  = 27'h0000123;
    localparam logic [AW-1:0] A_C0 = 27'h0000100;
    localparam logic [AW-1:0] A_C1 = 27'h0000200;
    localparam logic [DW-1:0] D_A5 = {16{8'hA5}};
    localparam logic [DW-1:0] D_B  = {8{16'h1111}};
    localparam logic [DW-1:0] D_E  = {4{32'hDEADBEEF}};

    logic            clk;
    logic            resetn;
    logic [N-1:0]    rv;
    logic [N*AW-1:0] raddr;
    logic [N-1:0]    rdy;
    logic [N-1:0]    cv;
    logic [DW-1:0]   cd;
    logic            mv;
    logic [AW-1:0]   ma;
    logic            mr;
    logic            sv;
    logic [DW-1:0]   sd;
    logic [3:0]      outs;
    logic            orph;

    int n_tests;
    int n_fail;

    mem_read_arbiter #(
        .NUM_CLIENTS (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TAG_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cl_req_valid_i (rv),
        .cl_req_addr_i  (raddr),
        .cl_req_ready_o (rdy),
        .cl_rsp_valid_o (cv),
        .cl_rsp_data_o  (cd),
        .mc_req_valid_o (mv),
        .mc_req_addr_o  (ma),
        .mc_req_ready_i (mr),
        .mc_rsp_valid_i (sv),
        .mc_rsp_data_i  (sd),
        .outstanding_o  (outs),
        .err_orphan_o   (orph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    rv;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          mr;
        logic          sv;
        logic [DW-1:0] sd;
        logic [1:0]    rdy;
        logic          mv;
        logic [AW-1:0] ma;
        logic [1:0]    cv;
        logic [DW-1:0] cd;
        logic [3:0]    outs;
        logic          orph;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int            m_lg;
    bit            m_pv;
    logic [AW-1:0] m_pa;
    int            m_q[$];
    bit            m_orph;
    logic [1:0]    m_cv;
    logic [DW-1:0] m_cd;

    function automatic vec_t mk(input logic [1:0] v_rv, input logic [AW-1:0] v_a0,
                                input logic [AW-1:0] v_a1, input logic v_mr, input logic v_sv,
                                input logic [DW-1:0] v_sd, input logic [1:0] v_rdy,
                                input logic v_mv, input logic [AW-1:0] v_ma,
                                input logic [1:0] v_cv, input logic [DW-1:0] v_cd,
                                input logic [3:0] v_outs, input logic v_orph);
        vec_t v;
        v.rv = v_rv;  v.a0 = v_a0;   v.a1 = v_a1;   v.mr = v_mr;     v.sv = v_sv;
        v.sd = v_sd;  v.rdy = v_rdy; v.mv = v_mv;   v.ma = v_ma;     v.cv = v_cv;
        v.cd = v_cd;  v.outs = v_outs; v.orph = v_orph;
        return v;
    endfunction

    function automatic logic [DW-1:0] dat(input int k);
        return {4{32'hC0DE_0000 | 32'(k)}};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational ready, then the registered outputs.
    task automatic run_vec(input vec_t v, input string tag);
        rv    = v.rv;
        raddr = {v.a1, v.a0};
        mr    = v.mr;
        sv    = v.sv;
        sd    = v.sd;
        #1;
        chk({tag, " cl_req_ready"}, 128'(rdy), 128'(v.rdy));
        @(posedge clk);
        #1;
        chk({tag, " mc_req_valid"}, 128'(mv), 128'(v.mv));
        chk({tag, " mc_req_addr"}, 128'(ma), 128'(v.ma));
        chk({tag, " cl_rsp_valid"}, 128'(cv), 128'(v.cv));
        chk({tag, " cl_rsp_data"}, cd, v.cd);
        chk({tag, " outstanding"}, 128'(outs), 128'(v.outs));
        chk({tag, " err_orphan"}, 128'(orph), 128'(v.orph));
    endtask

    task automatic model_reset();
        m_lg   = 0;
        m_pv   = 1'b0;
        m_pa   = '0;
        m_q    = {};
        m_orph = 1'b0;
        m_cv   = '0;
        m_cd   = '0;
    endtask

    task automatic rand_cycle();
        vec_t v;
        int   g;
        v.rv = 2'($urandom);
        v.a0 = AW'($urandom);
        v.a1 = AW'($urandom);
        v.mr = ($urandom_range(0, 9) < 7);
        v.sv = ($urandom_range(0, 9) < 4);
        v.sd = {$urandom, $urandom, $urandom, $urandom};
        g = -1;
        for (int k = 1; k <= int'(N); k++) begin
            if (g < 0 && ((int'(v.rv) >> ((m_lg + k) % N)) & 1) == 1) g = (m_lg + k) % N;
        end
        v.rdy = 2'b00;
        if (g >= 0 && (!m_pv || v.mr) && m_q.size() < int'(DEPTH)) v.rdy = 2'(1 << g);
        m_cv = '0;
        if (v.sv) begin
            if (m_q.size() == 0) begin
                m_orph = 1'b1;
            end else begin
                int t;
                t    = m_q.pop_front();
                m_cv = 2'(1 << t);
                m_cd = v.sd;
            end
        end
        if (v.rdy != 2'b00) begin
            m_q.push_back(g);
            m_lg = g;
            m_pv = 1'b1;
            m_pa = (g == 0) ? v.a0 : v.a1;
        end else if (v.mr) begin
            m_pv = 1'b0;
        end
        v.mv   = m_pv;
        v.ma   = m_pa;
        v.cv   = m_cv;
        v.cd   = m_cd;
        v.outs = 4'(m_q.size());
        v.orph = m_orph;
        run_vec(v, "rand");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        resetn  = 1'b0;
        rv      = '0;
        raddr   = '0;
        mr      = 1'b0;
        sv      = 1'b0;
        sd      = '0;

        // Single read
        tbl.push_back(mk(2'b01, A_SR, '0, 1'b1, 1'b0, '0, 2'b01, 1'b1, A_SR, 2'b00, '0, 4'd1, 1'b0));
        tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00, 1'b0, A_SR, 2'b00, '0, 4'd1, 1'b0));
        tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b1, D_A5, 2'b00, 1'b0, A_SR, 2'b01, D_A5, 4'd0,
                         1'b0));
        tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00, 1'b0, A_SR, 2'b00, D_A5, 4'd0,
                         1'b0));
        // Backpressure: five stalled cycles, then exactly one request leaves
        tbl.push_back(mk(2'b10, '0, A_BP, 1'b0, 1'b0, '0, 2'b10, 1'b1, A_BP, 2'b00, D_A5, 4'd1,
                         1'b0));
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(2'b11, A_X, A_BP, 1'b0, 1'b0, '0, 2'b00, 1'b1, A_BP, 2'b00, D_A5,
                             4'd1, 1'b0));
        end
        tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00, 1'b0, A_BP, 2'b00, D_A5, 4'd1,
                         1'b0));
        tbl.push_back(mk(2'b00, '0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0, A_BP, 2'b00, D_A5, 4'd1,
                         1'b0));
        tbl.push_back(mk(2'b00, '0, '0, 1'b0, 1'b1, D_B, 2'b00, 1'b0, A_BP, 2'b10, D_B, 4'd0,
                         1'b0));
        // Round-robin fill to full (last grant was client 1, so client 0 goes first)
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(2'b11, A_C0, A_C1, 1'b1, 1'b0, '0, (i % 2 == 1) ? 2'b10 : 2'b01,
                             1'b1, (i % 2 == 1) ? A_C1 : A_C0, 2'b00, D_B, 4'(i + 1), 1'b0));
        end
        tbl.push_back(mk(2'b11, A_C0, A_C1, 1'b1, 1'b0, '0, 2'b00, 1'b0, A_C1, 2'b00, D_B, 4'd8,
                         1'b0));
        // Pop while full still blocks; accepted the cycle after
        tbl.push_back(mk(2'b11, A_C0, A_C1, 1'b1, 1'b1, dat(0), 2'b00, 1'b0, A_C1, 2'b01, dat(0),
                         4'd7, 1'b0));
        tbl.push_back(mk(2'b11, A_C0, A_C1, 1'b1, 1'b1, dat(1), 2'b01, 1'b1, A_C0, 2'b10, dat(1),
                         4'd7, 1'b0));
        for (int k = 2; k <= 8; k++) begin
            tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b1, dat(k), 2'b00, 1'b0, A_C0,
                             (k % 2 == 0) ? 2'b01 : 2'b10, dat(k), 4'(8 - k), 1'b0));
        end
        // Orphan response, sticky
        tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b1, D_E, 2'b00, 1'b0, A_C0, 2'b00, dat(8), 4'd0,
                         1'b1));
        tbl.push_back(mk(2'b00, '0, '0, 1'b1, 1'b0, '0, 2'b00, 1'b0, A_C0, 2'b00, dat(8), 4'd0,
                         1'b1));

        // Reset state, with requests asserted
        #2;
        rv = 2'b11;
        #1;
        chk("reset cl_req_ready", 128'(rdy), 128'(2'b00));
        chk("reset mc_req_valid", 128'(mv), 128'(1'b0));
        chk("reset outstanding", 128'(outs), 128'(4'd0));
        chk("reset err_orphan", 128'(orph), 128'(1'b0));
        rv = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Async reset mid-burst with three reads outstanding
        rv    = 2'b11;
        raddr = {A_C1, A_C0};
        mr    = 1'b1;
        sv    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("burst outstanding", 128'(outs), 128'(4'd3));
        chk("burst mc_req_addr", 128'(ma), 128'(A_C1));
        #2;
        resetn = 1'b0;
        #1;
        chk("mid-reset cl_req_ready", 128'(rdy), 128'(2'b00));
        chk("mid-reset mc_req_valid", 128'(mv), 128'(1'b0));
        chk("mid-reset mc_req_addr", 128'(ma), 128'(0));
        chk("mid-reset cl_rsp_valid", 128'(cv), 128'(2'b00));
        chk("mid-reset cl_rsp_data", cd, 128'(0));
        chk("mid-reset outstanding", 128'(outs), 128'(4'd0));
        chk("mid-reset err_orphan", 128'(orph), 128'(1'b0));
        rv = '0;
        mr = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("post-reset vec%0d", i));
        run_vec(mk(2'b00, '0, '0, 1'b0, 1'b1, D_E, 2'b00, 1'b0, A_SR, 2'b00, D_A5, 4'd0, 1'b1),
                "late orphan");

        // Random traffic against the reference model
        #2;
        resetn = 1'b0;
        rv     = '0;
        mr     = 1'b0;
        sv     = 1'b0;
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 600; i++) rand_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Read-direction counterpart of the write-request merge path.
- Arbitrates read requests from NUM_CLIENTS requesters (client 0 = frame-buffer reader, client 1 = BVH fetch) onto the single memory-controller read port.
- Records the issuing client of every outstanding read in an in-order tag FIFO, then routes each returned data beat back to that client.
- Sits between the renderer/FB reader and the memory controller, in the clk domain.

Parameters:
- NUM_CLIENTS, 2, number of read requesters (2..4)
- ADDR_W, 27, memory address width
- DATA_W, 128, read data beat width
- TAG_DEPTH, 8, max outstanding reads; power of 2

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- cl_req_valid  in  NUM_CLIENTS  per-client read request valid
- cl_req_addr  in  NUM_CLIENTS*ADDR_W  per-client address; client i at bits [i*ADDR_W +: ADDR_W]
- cl_req_ready  out  NUM_CLIENTS  per-client accept
- cl_rsp_valid  out  NUM_CLIENTS  one-cycle pulse; data for client i
- cl_rsp_data  out  DATA_W  shared response data, qualified by cl_rsp_valid
- mc_req_valid  out  1  request to memory controller
- mc_req_addr  out  ADDR_W  address to memory controller
- mc_req_ready  in  1  memory controller accepts request
- mc_rsp_valid  in  1  memory controller returns one beat; responses are in request order
- mc_rsp_data  in  DATA_W  returned data
- outstanding  out  $clog2(TAG_DEPTH)+1  reads issued but not yet returned
- err_orphan  out  1  sticky; response arrived with no outstanding tag

Behaviour:
- Reset (async) clears all outputs and state:
  - mc_req_valid=0, mc_req_addr=0, cl_rsp_valid=0, cl_rsp_data=0, outstanding=0, err_orphan=0
  - tag FIFO empty; round-robin pointer = client 0
  - cl_req_ready=0 while resetn is low.
- Arbitration:
  - Round-robin. The search starts at the client after last_grant, among clients with cl_req_valid=1; this is combinational.
  - last_grant updates only on an accept.
- slot_free = !mc_req_valid || mc_req_ready.
- cl_req_ready[i] = (grant==i) && slot_free && !tag_full; all other bits are 0.
- Accept (cl_req_valid[i] && cl_req_ready[i]):
  - next cycle: mc_req_valid=1, mc_req_addr=that client's address
  - client index is pushed to the tag FIFO in the same cycle.
- Request latency: 1 cycle from accept to mc_req_valid.
- mc_req_valid and mc_req_addr are held stable until mc_req_ready=1.
- If mc_req_ready=1 and no accept occurs in that cycle, mc_req_valid goes to 0 the next cycle.
- Back-to-back: accept in the same cycle as mc_req_ready gives one request per cycle.
- tag_full = (count==TAG_DEPTH), evaluated on the registered count.
  - A pop in the same cycle does not unblock an accept; the accept is blocked for that cycle.
- Response (mc_rsp_valid=1 with FIFO non-empty):
  - pop head tag t
  - next cycle: cl_rsp_valid[t]=1 for exactly one cycle, cl_rsp_data=mc_rsp_data
  - response latency is 1 cycle.
- Clients have no response backpressure; they must take every pulse.
- Response with FIFO empty:
  - beat dropped, no cl_rsp_valid, err_orphan<=1, count unchanged
  - applies even if an accept happens in the same cycle.
- Simultaneous push and pop: count unchanged; the FIFO pointers both advance; the ordering contract holds.
- outstanding = tag FIFO count (registered).
  - Increments on push, not on MC acceptance.
  - Range 0..TAG_DEPTH; pointers wrap modulo TAG_DEPTH.
- cl_rsp_data holds its last value between pulses.
- Reset mid-operation drops all outstanding tags. Late MC responses arriving after reset set err_orphan; this is the intended visibility.

Decomposition:
- Shared memory package holds:
  - MEM_ADDR_W (27), MEM_DATA_W (128)
  - client-index enum: CLIENT_FB=0, CLIENT_BVH=1
- Parameter defaults reference these package constants.
- One sub-module: mem_read_tag_fifo.
  - Width $clog2(NUM_CLIENTS), depth TAG_DEPTH.
  - Ports: push, push_data, pop, pop_data, full, empty, count.
  - Asynchronous active-low reset.
- Arbiter, request register and response router stay in mem_read_arbiter.

Test Plan:
- Single read: client0 req addr 0x0001000, mc_req_ready=1 → mc_req_valid=1 with addr 0x0001000 one cycle later; outstanding=1. mc_rsp_valid with data 0xA5..A5 → cl_rsp_valid=2'b01 next cycle, data 0xA5..A5, outstanding=0.
- Round-robin: both clients valid continuously, mc_req_ready=1 → grants alternate 0,1,0,1 for 8 accepts; 8 responses route 0,1,0,1 with matching data tags.
- Backpressure: mc_req_ready=0 for 5 cycles with client1 addr 0x0ABCDEF pending → mc_req_addr stable at 0x0ABCDEF; cl_req_ready=0 to both clients after the first accept; release → exactly one MC request issued.
- Full: 8 accepts, no responses → outstanding=8, cl_req_ready=0. A response with a simultaneous request → the request is still blocked that cycle, outstanding=7, and it is accepted the following cycle.
- Orphan: mc_rsp_valid while outstanding=0 → no cl_rsp_valid, err_orphan=1 and it stays 1 until reset.
- Async reset: assert resetn=0 mid-burst with 3 outstanding → all outputs 0 immediately, outstanding=0; after release, a new request behaves as in the single-read scenario.
